mc_controller: RTL and testbench

- Multicycle MIPS main control FSM; replaces the single-cycle main decoder in the multicycle datapath.
- Consumes the instruction opcode and sequences fetch/decode/execute/memory/writeback.
- Drives datapath enables/muxes plus the 3-bit aluop that feeds the existing ALU decoder (funct + aluop -> alucontrol).
- It is the producing end of the aluop interface.

---
 rtl/mc_controller_if.sv | 45 ++++
 rtl/mc_controller.sv | 185 ++++++++++++++++++
 tb/tb_mc_controller.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/mc_controller_if.sv
// Control bundle between the multicycle main control FSM and the datapath.
// The controller sits on the master modport; the datapath on the slave modport.
// Optional macro MC_MEMREADY_EN adds the mem_ready handshake input.
interface mc_controller_if #(
   parameter int unsigned STATE_W = 4
);
   logic [5:0]         op;
`ifdef MC_MEMREADY_EN
   logic               mem_ready;
`endif
   logic               iord;
   logic               irwrite;
   logic               pcwrite;
   logic               branch;
   logic               branch_ne;
   logic               memwrite;
   logic               regwrite;
   logic               regdst;
   logic               memtoreg;
   logic               alusrca;
   logic [1:0]         alusrcb;
   logic [1:0]         pcsrc;
   logic [2:0]         aluop;
   logic               instr_done;
   logic               illegal_op;
   logic [STATE_W-1:0] dbg_state;

   modport master (
`ifdef MC_MEMREADY_EN
      input  mem_ready,
`endif
      input  op,
      output iord, irwrite, pcwrite, branch, branch_ne, memwrite, regwrite, regdst,
      output memtoreg, alusrca, alusrcb, pcsrc, aluop, instr_done, illegal_op, dbg_state
   );

   modport slave (
`ifdef MC_MEMREADY_EN
      output mem_ready,
`endif
      output op,
      input  iord, irwrite, pcwrite, branch, branch_ne, memwrite, regwrite, regdst,
      input  memtoreg, alusrca, alusrcb, pcsrc, aluop, instr_done, illegal_op, dbg_state
   );
endinterface

// File: rtl/mc_controller.sv
// Multicycle MIPS main control FSM: sequences fetch/decode/execute/memory/writeback
// and drives datapath enables, mux selects and the 3-bit aluop for the ALU decoder.
// Optional macro MC_MEMREADY_EN: FETCH, MEMRD and MEMWR wait for mem_ready.
module mc_controller #(
   parameter int unsigned STATE_W = 4
) (
   input logic            clk,
   input logic            reset,
   mc_controller_if.master bus
);

   typedef enum logic [STATE_W-1:0] {
      StFetch   = STATE_W'(0),
      StDecode  = STATE_W'(1),
      StMemAdr  = STATE_W'(2),
      StMemRd   = STATE_W'(3),
      StMemWb   = STATE_W'(4),
      StMemWr   = STATE_W'(5),
      StRtypeEx = STATE_W'(6),
      StAluWb   = STATE_W'(7),
      StBeqEx   = STATE_W'(8),
      StAddiEx  = STATE_W'(9),
      StAddiWb  = STATE_W'(10),
      StJEx     = STATE_W'(11),
      StBneEx   = STATE_W'(12)
   } state_e;

   localparam logic [5:0] OpRtype = 6'b000000;
   localparam logic [5:0] OpLw    = 6'b100011;
   localparam logic [5:0] OpSw    = 6'b101011;
   localparam logic [5:0] OpBeq   = 6'b000100;
   localparam logic [5:0] OpBne   = 6'b000101;
   localparam logic [5:0] OpAddi  = 6'b001000;
   localparam logic [5:0] OpJ     = 6'b000010;

   state_e state_q, state_d;
   logic   mem_ok;
   logic   op_known;

`ifdef MC_MEMREADY_EN
   assign mem_ok = bus.mem_ready;
`else
   assign mem_ok = 1'b1;
`endif

   // Opcode is supported by this controller
   always_comb begin
      op_known = 1'b0;
      unique case (bus.op)
         OpRtype, OpLw, OpSw, OpBeq, OpBne, OpAddi, OpJ: op_known = 1'b1;
         default:                                        op_known = 1'b0;
      endcase
   end

   // State register, asynchronously returned to FETCH
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= StFetch;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state sequencing
   always_comb begin
      state_d = StFetch;
      unique case (state_q)
         StFetch:  state_d = mem_ok ? StDecode : StFetch;
         StDecode: begin
            unique case (bus.op)
               OpLw, OpSw: state_d = StMemAdr;
               OpRtype:    state_d = StRtypeEx;
               OpBeq:      state_d = StBeqEx;
               OpBne:      state_d = StBneEx;
               OpAddi:     state_d = StAddiEx;
               OpJ:        state_d = StJEx;
               default:    state_d = StFetch;
            endcase
         end
         // op is held stable from DECODE, so it still selects load vs store here
         StMemAdr:  state_d = (bus.op == OpSw) ? StMemWr : StMemRd;
         StMemRd:   state_d = mem_ok ? StMemWb : StMemRd;
         StMemWb:   state_d = StFetch;
         StMemWr:   state_d = mem_ok ? StFetch : StMemWr;
         StRtypeEx: state_d = StAluWb;
         StAluWb:   state_d = StFetch;
         StBeqEx:   state_d = StFetch;
         StBneEx:   state_d = StFetch;
         StAddiEx:  state_d = StAddiWb;
         StAddiWb:  state_d = StFetch;
         StJEx:     state_d = StFetch;
         default:   state_d = StFetch;
      endcase
   end

   // Moore output decode; every output held at 0 while reset is asserted
   always_comb begin
      bus.iord       = 1'b0;
      bus.irwrite    = 1'b0;
      bus.pcwrite    = 1'b0;
      bus.branch     = 1'b0;
      bus.branch_ne  = 1'b0;
      bus.memwrite   = 1'b0;
      bus.regwrite   = 1'b0;
      bus.regdst     = 1'b0;
      bus.memtoreg   = 1'b0;
      bus.alusrca    = 1'b0;
      bus.alusrcb    = 2'b00;
      bus.pcsrc      = 2'b00;
      bus.aluop      = 3'b000;
      bus.instr_done = 1'b0;
      bus.illegal_op = 1'b0;
      bus.dbg_state  = '0;
      if (reset) begin
         bus.dbg_state = state_q;
         unique case (state_q)
            StFetch: begin
               // Gate the loads so the PC advances once however long memory stalls
               bus.irwrite = mem_ok;
               bus.pcwrite = mem_ok;
               bus.alusrcb = 2'b01;
            end
            StDecode: begin
               bus.alusrcb    = 2'b11;
               bus.illegal_op = ~op_known;
            end
            StMemAdr: begin
               bus.alusrca = 1'b1;
               bus.alusrcb = 2'b10;
            end
            StMemRd: begin
               bus.iord = 1'b1;
            end
            StMemWb: begin
               bus.regwrite   = 1'b1;
               bus.memtoreg   = 1'b1;
               bus.instr_done = 1'b1;
            end
            StMemWr: begin
               bus.iord       = 1'b1;
               bus.memwrite   = 1'b1;
               bus.instr_done = mem_ok;
            end
            StRtypeEx: begin
               bus.alusrca = 1'b1;
               bus.aluop   = 3'b100;
            end
            StAluWb: begin
               bus.regwrite   = 1'b1;
               bus.regdst     = 1'b1;
               bus.instr_done = 1'b1;
            end
            StBeqEx: begin
               bus.alusrca    = 1'b1;
               bus.aluop      = 3'b001;
               bus.pcsrc      = 2'b01;
               bus.branch     = 1'b1;
               bus.instr_done = 1'b1;
            end
            StBneEx: begin
               bus.alusrca    = 1'b1;
               bus.aluop      = 3'b011;
               bus.pcsrc      = 2'b01;
               bus.branch_ne  = 1'b1;
               bus.instr_done = 1'b1;
            end
            StAddiEx: begin
               bus.alusrca = 1'b1;
               bus.alusrcb = 2'b10;
            end
            StAddiWb: begin
               bus.regwrite   = 1'b1;
               bus.instr_done = 1'b1;
            end
            StJEx: begin
               bus.pcwrite    = 1'b1;
               bus.pcsrc      = 2'b10;
               bus.instr_done = 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mc_controller.sv
// Directed, table-driven bench for mc_controller: per-cycle expected state code
// and packed output vector, plus hand sequences for mid-instruction reset and
// (with MC_MEMREADY_EN) the fetch stall.
module tb_mc_controller;

   logic clk;
   logic reset;

   mc_controller_if #(.STATE_W(4)) bus ();

   mc_controller #(.STATE_W(4)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Packed output order:
   // iord irwrite pcwrite branch branch_ne memwrite regwrite regdst memtoreg alusrca
   // _ alusrcb _ pcsrc _ aluop _ instr_done _ illegal_op
   localparam logic [18:0] O_ZERO   = 19'b0000000000_00_00_000_0_0;
   localparam logic [18:0] O_FETCH  = 19'b0110000000_01_00_000_0_0;
   localparam logic [18:0] O_DECODE = 19'b0000000000_11_00_000_0_0;
   localparam logic [18:0] O_ILLDEC = 19'b0000000000_11_00_000_0_1;
   localparam logic [18:0] O_MEMADR = 19'b0000000001_10_00_000_0_0;
   localparam logic [18:0] O_MEMRD  = 19'b1000000000_00_00_000_0_0;
   localparam logic [18:0] O_MEMWB  = 19'b0000001010_00_00_000_1_0;
   localparam logic [18:0] O_MEMWR  = 19'b1000010000_00_00_000_1_0;
   localparam logic [18:0] O_RTEX   = 19'b0000000001_00_00_100_0_0;
   localparam logic [18:0] O_ALUWB  = 19'b0000001100_00_00_000_1_0;
   localparam logic [18:0] O_BEQEX  = 19'b0001000001_00_01_001_1_0;
   localparam logic [18:0] O_BNEEX  = 19'b0000100001_00_01_011_1_0;
   localparam logic [18:0] O_ADDIEX = 19'b0000000001_10_00_000_0_0;
   localparam logic [18:0] O_ADDIWB = 19'b0000001000_00_00_000_1_0;
   localparam logic [18:0] O_JEX    = 19'b0010000000_00_10_000_1_0;
   localparam logic [18:0] O_STALL  = 19'b0000000000_01_00_000_0_0;

   localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
   localparam logic [5:0] BEQ = 6'b000100, BNE = 6'b000101, ADDI = 6'b001000;
   localparam logic [5:0] JMP = 6'b000010, BAD = 6'b111111;

   typedef struct {
      logic        rst;
      logic [5:0]  op;
      logic [3:0]  st;
      logic [18:0] outs;
   } vec_t;

   vec_t vecs[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   function automatic logic [18:0] act_outs();
      return {bus.iord, bus.irwrite, bus.pcwrite, bus.branch, bus.branch_ne, bus.memwrite,
              bus.regwrite, bus.regdst, bus.memtoreg, bus.alusrca, bus.alusrcb, bus.pcsrc,
              bus.aluop, bus.instr_done, bus.illegal_op};
   endfunction

   task automatic check(input string name, input logic [3:0] st, input logic [18:0] outs);
      n_cmp++;
      if (bus.dbg_state !== st) begin
         n_bad++;
         $display("FAIL %s state: got %0d want %0d", name, bus.dbg_state, st);
      end
      n_cmp++;
      if (act_outs() !== outs) begin
         n_bad++;
         $display("FAIL %s outputs: got %b want %b", name, act_outs(), outs);
      end
      n_cmp++;
      if ((bus.branch & bus.branch_ne) || (bus.pcwrite & bus.memwrite)) begin
         n_bad++;
         $display("FAIL %s exclusivity: got br=%b bne=%b pcw=%b mw=%b want no pair set",
                  name, bus.branch, bus.branch_ne, bus.pcwrite, bus.memwrite);
      end
   endtask

   // Drive at the falling edge, compare 1 ns later, mid low phase
   task automatic step(input string name, input logic rst, input logic [5:0] op,
                       input logic [3:0] st, input logic [18:0] outs);
      @(negedge clk);
      reset  = rst;
      bus.op = op;
      #1;
      check(name, st, outs);
   endtask

   function automatic void add(input logic rst, input logic [5:0] op, input logic [3:0] st,
                               input logic [18:0] outs);
      vec_t v;
      v.rst = rst; v.op = op; v.st = st; v.outs = outs;
      vecs.push_back(v);
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset  = 1'b0;
      bus.op = 6'b0;
`ifdef MC_MEMREADY_EN
      bus.mem_ready = 1'b1;
`endif
      // Reset held three cycles, then instruction sequences
      add(0, RT, 0, O_ZERO); add(0, RT, 0, O_ZERO); add(0, RT, 0, O_ZERO);
      add(1, LW, 0, O_FETCH); add(1, LW, 1, O_DECODE); add(1, LW, 2, O_MEMADR);
      add(1, LW, 3, O_MEMRD); add(1, LW, 4, O_MEMWB);
      add(1, SW, 0, O_FETCH); add(1, SW, 1, O_DECODE); add(1, SW, 2, O_MEMADR);
      add(1, SW, 5, O_MEMWR);
      add(1, RT, 0, O_FETCH); add(1, RT, 1, O_DECODE); add(1, RT, 6, O_RTEX);
      add(1, RT, 7, O_ALUWB);
      add(1, RT, 0, O_FETCH); add(1, RT, 1, O_DECODE); add(1, RT, 6, O_RTEX);
      add(1, RT, 7, O_ALUWB);
      add(1, BEQ, 0, O_FETCH); add(1, BEQ, 1, O_DECODE); add(1, BEQ, 8, O_BEQEX);
      add(1, BNE, 0, O_FETCH); add(1, BNE, 1, O_DECODE); add(1, BNE, 12, O_BNEEX);
      add(1, ADDI, 0, O_FETCH); add(1, ADDI, 1, O_DECODE); add(1, ADDI, 9, O_ADDIEX);
      add(1, ADDI, 10, O_ADDIWB);
      add(1, JMP, 0, O_FETCH); add(1, JMP, 1, O_DECODE); add(1, JMP, 11, O_JEX);
      add(1, BAD, 0, O_FETCH); add(1, BAD, 1, O_ILLDEC);
      add(1, LW, 0, O_FETCH);

      foreach (vecs[i]) begin
         step($sformatf("vec%0d", i), vecs[i].rst, vecs[i].op, vecs[i].st, vecs[i].outs);
      end

      // Reset asserted in MEMRD: outputs drop at once, restart at FETCH
      step("abort_dec", 1, LW, 1, O_DECODE);
      step("abort_adr", 1, LW, 2, O_MEMADR);
      step("abort_rd", 1, LW, 3, O_MEMRD);
      #1 reset = 1'b0;
      #1 check("abort_now", 0, O_ZERO);
      step("abort_hold", 0, LW, 0, O_ZERO);
      step("abort_fetch", 1, LW, 0, O_FETCH);
      step("abort_decode", 1, LW, 1, O_DECODE);

`ifdef MC_MEMREADY_EN
      // Fetch stall: four cycles with mem_ready low, one pcwrite pulse on release
      step("mr_rst", 0, RT, 0, O_ZERO);
      bus.mem_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step($sformatf("mr_stall%0d", i), 1, RT, 0, O_STALL);
      end
      @(negedge clk);
      bus.mem_ready = 1'b1;
      #1 check("mr_go", 0, O_FETCH);
      step("mr_decode", 1, RT, 1, O_DECODE);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
